// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: mode encodings and control FSM states.
package alu_pkg;

  localparam int MODE_W = 4;

  localparam logic [MODE_W-1:0] MODE_ADD = 4'd0;
  localparam logic [MODE_W-1:0] MODE_SUB = 4'd1;
  localparam logic [MODE_W-1:0] MODE_CMP = 4'd2;
  localparam logic [MODE_W-1:0] MODE_AND = 4'd3;
  localparam logic [MODE_W-1:0] MODE_OR  = 4'd4;
  localparam logic [MODE_W-1:0] MODE_XOR = 4'd5;
  localparam logic [MODE_W-1:0] MODE_ADC = 4'd6;
  localparam logic [MODE_W-1:0] MODE_SBB = 4'd7;
  localparam logic [MODE_W-1:0] MODE_SHL = 4'd8;
  localparam logic [MODE_W-1:0] MODE_SHR = 4'd9;
  localparam logic [MODE_W-1:0] MODE_MUL = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per clock, WIDTH iterations after start.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               run_q;

  // done marks the edge that performs the final iteration; product is complete after it.
  assign done    = run_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign product = acc_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with held zero/carry flags, carry-chained ops and a multi-cycle multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic [MODE_W-1:0] mode,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               valid_q, valid_d;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  assign busy       = (state_q != ST_IDLE);
  assign in_ready   = ~busy;
  assign accept     = in_valid & in_ready;
  assign out        = out_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign out_valid  = valid_q;

  // Carry-in/borrow-in only for the chained modes; the MSB of each sum is the new carry.
  assign cin  = ((mode == MODE_ADC) || (mode == MODE_SBB)) ? carry_q : 1'b0;
  assign sum  = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, cin};
  assign diff = {1'b0, in2} - {1'b0, in1} - {{WIDTH{1'b0}}, cin};

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (in1),
        .b       (in2),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    valid_d   = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          valid_d = 1'b1;
          case (mode)
            MODE_ADD, MODE_ADC: {carry_d, out_d} = sum;
            MODE_SUB, MODE_SBB: {carry_d, out_d} = diff;
            MODE_CMP: begin
              out_d   = in2;
              carry_d = (in1 > in2);
              zero_d  = (in1 == in2);
            end
            MODE_AND: out_d = in1 & in2;
            MODE_OR:  out_d = in1 | in2;
            MODE_XOR: out_d = in1 ^ in2;
            MODE_SHL: begin
              out_d   = {in1[WIDTH-2:0], 1'b0};
              carry_d = in1[WIDTH-1];
            end
            MODE_SHR: begin
              out_d   = {1'b0, in1[WIDTH-1:1]};
              carry_d = in1[0];
            end
            MODE_MUL: begin
              if (MUL_EN) begin
                mul_start = 1'b1;
                valid_d   = 1'b0;
                state_d   = ST_BUSY;
              end
            end
            default: ;
          endcase
          if ((mode <= MODE_SHR) && (mode != MODE_CMP)) zero_d = (out_d == '0);
        end
      end
      ST_BUSY: begin
        if (mul_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_d   = mul_product[WIDTH-1:0];
        carry_d = |mul_product[2*WIDTH-1:WIDTH];
        zero_d  = (mul_product == '0);
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 with the multiplier enabled.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [3:0] mode;
  logic       out_valid;
  logic [7:0] out;
  logic       flag_zero;
  logic       flag_carry;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .mode       (mode),
    .out_valid  (out_valid),
    .out        (out),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] eo, input logic ec,
                         input logic ez, input logic ev);
    check({tag, ".out"},   16'(out),        16'(eo));
    check({tag, ".carry"}, 16'(flag_carry), 16'(ec));
    check({tag, ".zero"},  16'(flag_zero),  16'(ez));
    check({tag, ".valid"}, 16'(out_valid),  16'(ev));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    mode     = m;
    in1      = a;
    in2      = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in1      = 8'h00;
    in2      = 8'h00;
    mode     = 4'd0;
    tick();
    tick();
    chk_res("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset.busy",  16'(busy),     16'(0));
    check("reset.ready", 16'(in_ready), 16'(1));
    rst = 1'b0;
    tick();

    // Wrap-around add, then the valid pulse must drop after one cycle.
    drive(4'd0, 8'hFF, 8'h01); tick(); in_valid = 1'b0;
    chk_res("add_wrap", 8'h00, 1'b1, 1'b1, 1'b1);
    tick();
    chk_res("add_wrap_hold", 8'h00, 1'b1, 1'b1, 1'b0);

    // SUB borrows, SBB consumes that borrow.
    drive(4'd1, 8'h05, 8'h03); tick();
    chk_res("sub", 8'hFE, 1'b1, 1'b0, 1'b1);
    drive(4'd7, 8'h00, 8'h10); tick(); in_valid = 1'b0;
    chk_res("sbb", 8'h0F, 1'b0, 1'b0, 1'b1);

    drive(4'd2, 8'h42, 8'h42); tick();
    chk_res("cmp_eq", 8'h42, 1'b0, 1'b1, 1'b1);
    drive(4'd3, 8'hF0, 8'h0F); tick();
    chk_res("and", 8'h00, 1'b0, 1'b1, 1'b1);

    // Logic ops and NOP hold a set carry; ADC consumes it.
    drive(4'd0, 8'h80, 8'h80); tick();
    chk_res("add_80", 8'h00, 1'b1, 1'b1, 1'b1);
    drive(4'd5, 8'h0F, 8'hF0); tick();
    chk_res("xor", 8'hFF, 1'b1, 1'b0, 1'b1);
    drive(4'd12, 8'h00, 8'h00); tick();
    chk_res("nop", 8'hFF, 1'b1, 1'b0, 1'b1);
    drive(4'd6, 8'h01, 8'h01); tick();
    chk_res("adc", 8'h03, 1'b0, 1'b0, 1'b1);
    drive(4'd8, 8'h81, 8'h00); tick(); in_valid = 1'b0;
    chk_res("shl", 8'h02, 1'b1, 1'b0, 1'b1);
    tick();

    // MUL 0x10 * 0x11 = 0x0110; requests during busy must be ignored.
    drive(4'd10, 8'h10, 8'h11); tick();
    drive(4'd0, 8'hFF, 8'hFF);
    check("mul.busy0",  16'(busy),      16'(1));
    check("mul.ready0", 16'(in_ready),  16'(0));
    check("mul.valid0", 16'(out_valid), 16'(0));
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("mul.busy%0d", i),  16'(busy),      16'(1));
      check($sformatf("mul.valid%0d", i), 16'(out_valid), 16'(0));
    end
    tick(); in_valid = 1'b0;
    check("mul.busy_end", 16'(busy), 16'(0));
    chk_res("mul", 8'h10, 1'b1, 1'b0, 1'b1);
    tick();
    chk_res("mul_hold", 8'h10, 1'b1, 1'b0, 1'b0);

    drive(4'd10, 8'h00, 8'h55); tick(); in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk_res("mul_zero", 8'h00, 1'b0, 1'b1, 1'b1);

    // Back-to-back single-cycle ops.
    drive(4'd0, 8'h01, 8'h01); tick();
    chk_res("b2b_add1", 8'h02, 1'b0, 1'b0, 1'b1);
    drive(4'd0, 8'h02, 8'h02); tick();
    chk_res("b2b_add2", 8'h04, 1'b0, 1'b0, 1'b1);
    drive(4'd9, 8'h81, 8'h00); tick(); in_valid = 1'b0;
    chk_res("b2b_shr", 8'h40, 1'b1, 1'b0, 1'b1);
    tick();
    check("b2b_drop", 16'(out_valid), 16'(0));

    // Reset during a multiply aborts it cleanly.
    drive(4'd10, 8'h10, 8'h11); tick(); in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_res("mul_abort", 8'h00, 1'b0, 1'b0, 1'b0);
    check("mul_abort.busy",  16'(busy),     16'(0));
    check("mul_abort.ready", 16'(in_ready), 16'(1));
    drive(4'd0, 8'h03, 8'h04); tick(); in_valid = 1'b0;
    chk_res("post_abort_add", 8'h07, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("post_abort_quiet%0d", i), 16'(out_valid), 16'(0));
    end
    check("post_abort_out", 16'(out), 16'(8'h07));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
